// File: rtl/experiment_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// experiment_sequencer_pkg
// Shared types and constants for the shot sequencer:
//   state_t  - sequencer state encoding (visible on the `state` port)
//   fault_t  - fault code reported on `fault_code`
//   SYNC_DEPTH - number of flops in each input synchroniser
// ---------------------------------------------------------------------------
package experiment_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_FG_WAIT       = 3'd1,
    ST_FG_DELAY      = 3'd2,
    ST_DETONATE      = 3'd3,
    ST_WIRE_WAIT     = 3'd4,
    ST_DETECTOR_WAIT = 3'd5,
    ST_FINISHED      = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    FAULT_NONE             = 3'd0,
    FAULT_FG_TIMEOUT       = 3'd1,
    FAULT_WIRE_TIMEOUT     = 3'd2,
    FAULT_DETECTOR_TIMEOUT = 3'd3,
    FAULT_ABORT            = 3'd4,
    FAULT_EMPTY_MASK       = 3'd5
  } fault_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Multi-bit flop-chain synchroniser (SYNC_DEPTH stages) for asynchronous
// level inputs. Each bit is synchronised independently.
// Ports:
//   clock   - destination clock
//   reset_n - asynchronous active-low reset, clears every stage
//   d       - asynchronous input bits
//   q       - synchronised output bits
// ---------------------------------------------------------------------------
module sync_bit
  import experiment_sequencer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/experiment_sequencer.sv
// ---------------------------------------------------------------------------
// experiment_sequencer
// Multi-channel shot sequencer. A start edge arms the shot, the FG pulse
// starts a fixed delay, a fixed-width detonation pulse follows, the wire-break
// fires the enabled trigger channels and each channel is released by its own
// detector-ready. Every waiting stage has a timeout; abort returns to IDLE.
// Ports:
//   clock, reset_n      - clock, asynchronous active-low reset
//   start_signal        - async, rising edge arms a shot
//   abort               - async level, cancels a running shot
//   fg_signal           - async function-generator pulse
//   wire_signal         - async wire-break level
//   detector_ready      - async per-channel release
//   trigger_mask        - channel enables, captured when a start is accepted
//   detonation_signal   - detonator pulse
//   output_trigger      - per-channel triggers
//   busy                - high whenever not IDLE
//   done                - one-cycle pulse when a shot completes
//   fault_code          - last fault (held until the next accepted start)
//   state               - current state encoding
// ---------------------------------------------------------------------------
module experiment_sequencer
  import experiment_sequencer_pkg::*;
#(
  parameter int N_CH             = 4,
  parameter int CNT_W            = 32,
  parameter int FG_DELAY         = 400_000,
  parameter int DET_WIDTH        = 50,
  parameter int FG_TIMEOUT       = 0,
  parameter int WIRE_TIMEOUT     = 1_000_000,
  parameter int DETECTOR_TIMEOUT = 500
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start_signal,
  input  logic            abort,
  input  logic            fg_signal,
  input  logic            wire_signal,
  input  logic [N_CH-1:0] detector_ready,
  input  logic [N_CH-1:0] trigger_mask,
  output logic            detonation_signal,
  output logic [N_CH-1:0] output_trigger,
  output logic            busy,
  output logic            done,
  output logic [2:0]      fault_code,
  output logic [2:0]      state
);

  // Terminal counter values; FG_TIMEOUT = 0 disables that timeout entirely.
  localparam logic [CNT_W-1:0] FG_DELAY_LAST = CNT_W'(FG_DELAY - 1);
  localparam logic [CNT_W-1:0] DET_LAST      = CNT_W'(DET_WIDTH - 1);
  localparam logic [CNT_W-1:0] FG_TO_LAST    = CNT_W'((FG_TIMEOUT == 0) ? 0 : FG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WIRE_TO_LAST  = CNT_W'(WIRE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DET_TO_LAST   = CNT_W'(DETECTOR_TIMEOUT - 1);

  logic [3:0]      ctrl_s;
  logic [N_CH-1:0] ready_s;
  logic            start_s, abort_s, fg_s, wire_s;

  // ---- input synchronisers ----
  sync_bit #(.WIDTH(4)) u_sync_ctrl (
    .clock   (clock),
    .reset_n (reset_n),
    .d       ({start_signal, abort, fg_signal, wire_signal}),
    .q       (ctrl_s)
  );

  sync_bit #(.WIDTH(N_CH)) u_sync_ready (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (detector_ready),
    .q       (ready_s)
  );

  assign start_s = ctrl_s[3];
  assign abort_s = ctrl_s[2];
  assign fg_s    = ctrl_s[1];
  assign wire_s  = ctrl_s[0];

  // ---- start edge detect (registered, one extra cycle of latency) ----
  logic start_prev_q, start_edge_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_prev_q <= 1'b0;
      start_edge_q <= 1'b0;
    end else begin
      start_prev_q <= start_s;
      start_edge_q <= start_s & ~start_prev_q;
    end
  end

  // ---- FSM: state, counter, latched mask and all outputs registered ----
  state_t          state_q, state_d;
  fault_t          fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] trig_q, trig_d;
  logic            det_q, det_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      fault_q <= FAULT_NONE;
      cnt_q   <= '0;
      mask_q  <= '0;
      trig_q  <= '0;
      det_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      trig_q  <= trig_d;
      det_q   <= det_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    mask_d  = mask_q;
    trig_d  = trig_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        trig_d = '0;
        if (start_edge_q) begin
          if (trigger_mask != '0) begin
            mask_d  = trigger_mask;
            fault_d = FAULT_NONE;
            state_d = ST_FG_WAIT;
          end else begin
            fault_d = FAULT_EMPTY_MASK;
          end
        end
      end
      ST_FG_WAIT: begin
        if (fg_s) begin
          state_d = ST_FG_DELAY;
        end else if ((FG_TIMEOUT != 0) && (cnt_q == FG_TO_LAST)) begin
          state_d = ST_IDLE;
          fault_d = FAULT_FG_TIMEOUT;
        end
      end
      ST_FG_DELAY: begin
        if (cnt_q == FG_DELAY_LAST) state_d = ST_DETONATE;
      end
      ST_DETONATE: begin
        if (cnt_q == DET_LAST) state_d = ST_WIRE_WAIT;
      end
      ST_WIRE_WAIT: begin
        if (wire_s) begin
          state_d = ST_DETECTOR_WAIT;
          trig_d  = mask_q;
        end else if (cnt_q == WIRE_TO_LAST) begin
          state_d = ST_IDLE;
          fault_d = FAULT_WIRE_TIMEOUT;
        end
      end
      ST_DETECTOR_WAIT: begin
        // Release individually; completing on the timeout cycle is not a fault.
        trig_d = trig_q & ~ready_s;
        if (trig_d == '0) begin
          state_d = ST_FINISHED;
        end else if (cnt_q == DET_TO_LAST) begin
          trig_d  = '0;
          state_d = ST_FINISHED;
          fault_d = FAULT_DETECTOR_TIMEOUT;
        end
      end
      ST_FINISHED: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        trig_d  = '0;
      end
    endcase

    // Abort overrides every transition computed above.
    if (abort_s && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      trig_d  = '0;
      fault_d = FAULT_ABORT;
      done_d  = 1'b0;
    end

    if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
    else                                          cnt_d = cnt_q + 1'b1;

    det_d  = (state_d == ST_DETONATE);
    busy_d = (state_d != ST_IDLE);
  end

  assign detonation_signal = det_q;
  assign output_trigger    = trig_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign fault_code        = fault_q;
  assign state             = state_q;

endmodule

// File: doc/experiment_sequencer.md
# experiment_sequencer

Parametrised multi-channel shot sequencer for the synchronisation block. It is armed by a start edge and waits for the function-generator pulse. After a programmable delay it issues a fixed-width detonation pulse, then fires the enabled trigger channels on the wire-break signal and releases each channel on its own detector-ready. It adds per-stage timeouts, abort, a channel mask, fault reporting and input synchronisation, and sits between the front-panel/host control and the detonator/detector outputs.

## Interface
Parameters:
- `N_CH`, 4: number of trigger/detector channel pairs (1..8).
- `CNT_W`, 32: width of the shared stage counter.
- `FG_DELAY`, 400_000: cycles from FG pulse to detonation (≥1).
- `DET_WIDTH`, 50: detonation pulse width in cycles (≥1).
- `FG_TIMEOUT`, 0: max cycles in FG_WAIT; 0 = wait forever.
- `WIRE_TIMEOUT`, 1_000_000: max cycles in WIRE_WAIT (≥1).
- `DETECTOR_TIMEOUT`, 500: max cycles in DETECTOR_WAIT (≥1).

All counts must fit in `CNT_W`.

Ports:
- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_signal` in 1: async; rising edge arms a shot.
- `abort` in 1: async; level, returns to IDLE.
- `fg_signal` in 1: async; function-generator pulse.
- `wire_signal` in 1: async; wire-break level.
- `detector_ready` in N_CH: async; per-channel release.
- `trigger_mask` in N_CH: channel enables, sampled on accepted start.
- `detonation_signal` out 1: detonator pulse.
- `output_trigger` out N_CH: per-channel triggers.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse on FINISHED→IDLE.
- `fault_code` out 3: 0 none, 1 FG timeout, 2 wire timeout, 3 detector timeout, 4 abort, 5 empty mask.
- `state` out 3: current state encoding.

## Operation
- All async inputs pass through a 2-flop synchroniser. `start_signal` is additionally rising-edge detected; all other inputs are used as levels.
- States are IDLE, FG_WAIT, FG_DELAY, DETONATE, WIRE_WAIT, DETECTOR_WAIT and FINISHED. A single counter is cleared on every state change.
- IDLE: on a start edge with `trigger_mask`≠0, latch the mask, clear `fault_code`, and go to FG_WAIT. On a start edge with mask = 0, stay in IDLE and set `fault_code`=5.
- FG_WAIT: `fg_signal` high → FG_DELAY. If `FG_TIMEOUT`≠0 and the counter reaches `FG_TIMEOUT`-1 → IDLE with code 1. `fg_signal` wins over timeout in the same cycle.
- FG_DELAY: on counter = `FG_DELAY`-1 → DETONATE.
- DETONATE: `detonation_signal`=1 for exactly `DET_WIDTH` cycles, then → WIRE_WAIT.
- WIRE_WAIT: `wire_signal` high → DETECTOR_WAIT and set `output_trigger` = latched mask. On counter = `WIRE_TIMEOUT`-1 → IDLE with code 2. Wire wins over timeout.
- DETECTOR_WAIT: each held channel clears when its synchronised `detector_ready` is high. When all channels are cleared → FINISHED. On counter = `DETECTOR_TIMEOUT`-1, clear all triggers and → FINISHED with code 3.
- FINISHED: one cycle, then IDLE with `done`=1.
- Abort: a synchronised `abort` high in any non-IDLE state → IDLE next edge. All outputs go low, code 4, no `done`. Abort has priority over every other transition.
- Start edges while `busy` are ignored, not queued.
- Faults hold `fault_code` until the next accepted start.
- Unused/illegal state encodings → IDLE.

## Timing
- Reset (`reset_n` low) is immediate. State goes to IDLE and the counter, latched mask, all outputs and `fault_code` go to 0. Reset mid-shot drops detonation/triggers asynchronously.
- All outputs are registered, with no combinational path from inputs.
- Input-to-state latency: 2 synchroniser cycles + edge detect (start) + 1 edge. Start pin rise → `busy` high is 4 cycles.
- FG_DELAY dwell is exactly `FG_DELAY` cycles. The detonation high time is exactly `DET_WIDTH` cycles.
- Triggers rise on the same edge the state enters DETECTOR_WAIT. Each trigger is high for ≥1 cycle even if its ready was already high. A channel drops 1 edge after its synchronised ready is seen.
- `done` rises exactly 1 cycle after the last trigger drops.

## Structure
- Package `experiment_sequencer_pkg` holds:
  - the state enum (`logic [2:0]`);
  - the fault-code enum;
  - the synchroniser depth constant (2).
- Sub-module `sync_bit`: a parametrised-width 2-flop synchroniser with async active-low reset. It is instantiated once for the control bits and once for `detector_ready`.
- The edge detector and the FSM live in `experiment_sequencer`.

## Test plan
- Nominal, N_CH=4, FG_DELAY=10, DET_WIDTH=5, mask 4'b1011: start → fg → wire → readies at +3, +5, +7 → detonation high exactly 5 cycles after 10-cycle dwell; triggers 1011 on wire; each drops individually; `done` pulse; `fault_code`=0.
- Wire timeout, WIRE_TIMEOUT=20, no wire → IDLE after 20 cycles in WIRE_WAIT; `fault_code`=2; triggers never asserted; no `done`.
- Detector timeout, DETECTOR_TIMEOUT=8, channel 2 never ready → all triggers low after 8 cycles; `done`=1; `fault_code`=3.
- Abort mid-DETONATE → `detonation_signal` low on the edge after sync; state IDLE; `fault_code`=4; restart then completes normally with code cleared.
- Mask 0 start → stays IDLE, `busy` low, `fault_code`=5. Start edge during FG_DELAY → ignored; dwell unchanged.
- `reset_n` low during DETECTOR_WAIT → triggers low immediately with no clock edge; all outputs 0; `state`=IDLE.
